// File: rtl/rfin_pkt_receiver.sv
// RF link receive front end: preamble lock, pulse-position bit recovery, 64-bit payload delivery.
// Optional build macro RFRX_GLITCH_FILTER_EN requires rs high for two cycles before an edge counts.
//
// state | meaning
// IDLE  | receiver disabled (RX=0), frame state cleared
// HUNT  | waiting for the first preamble pulse
// PRE   | counting preamble pulses inside the acceptance window
// DATA  | deserializing payload bits, one decision per slot
module rfin_pkt_receiver #(
   parameter int BIT_CLKS = 10000,
   parameter int WIN_CLKS = 1000,
   parameter int PRE_LEN  = 8
) (
   input  logic        i_PCLK,
   input  logic        i_PRESET,
   input  logic        rfin,
   input  logic        RX,
   input  logic        pkt_ack,
   output logic        pkt_rec,
   output logic [63:0] pkt_data,
   output logic        rx_busy,
   output logic        rx_err,
   output logic        overflow
);

   localparam int CNT_W = $clog2(BIT_CLKS + WIN_CLKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(BIT_CLKS + WIN_CLKS);
   localparam logic [CNT_W-1:0] WIN_OPEN   = CNT_W'(BIT_CLKS - WIN_CLKS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_RESYNC = CNT_W'(WIN_CLKS + 1);
   localparam logic [3:0]       PRE_LAST   = 4'(PRE_LEN - 1);

   typedef enum logic [1:0] {IDLE, HUNT, PRE, DATA} state_t;

   state_t           state, state_nxt;
   logic             rs_meta, rs, rs_d;
   logic             edge_raw, edge_q;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [3:0]       pcnt, pcnt_nxt;
   logic [6:0]       bcnt, bcnt_nxt;
   logic [63:0]      sh, sh_nxt, pkt_word;
   logic             in_win, timeout, deliver, err_nxt;

`ifdef RFRX_GLITCH_FILTER_EN
   logic rs_dd;
   assign edge_raw = rs & rs_d & ~rs_dd;
`else
   assign edge_raw = rs & ~rs_d;
`endif

   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         rs_meta <= 1'b0;
         rs      <= 1'b0;
         rs_d    <= 1'b0;
`ifdef RFRX_GLITCH_FILTER_EN
         rs_dd   <= 1'b0;
`endif
         edge_q  <= 1'b0;
      end else begin
         rs_meta <= rfin;
         rs      <= rs_meta;
         rs_d    <= rs;
`ifdef RFRX_GLITCH_FILTER_EN
         rs_dd   <= rs_d;
`endif
         edge_q  <= edge_raw;
      end
   end

   // The reference cycle itself counts as the loaded value, so the register is loaded with value+1.
   // This keeps cnt equal to BIT_CLKS at a nominal pulse and avoids drift across runs of zeros.
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   assign in_win   = (cnt >= WIN_OPEN);
   assign timeout  = (cnt == CNT_MAX);
   assign pkt_word = {sh[62:0], edge_q};
   assign rx_busy  = (state == PRE) || (state == DATA);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_inc;
      pcnt_nxt  = pcnt;
      bcnt_nxt  = bcnt;
      sh_nxt    = sh;
      deliver   = 1'b0;
      err_nxt   = 1'b0;
      if (!RX) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         pcnt_nxt  = '0;
         bcnt_nxt  = '0;
         sh_nxt    = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = HUNT;
               cnt_nxt   = '0;
            end
            HUNT: begin
               if (edge_q) begin
                  state_nxt = PRE;
                  cnt_nxt   = CNT_ONE;
                  pcnt_nxt  = 4'd1;
               end
            end
            PRE: begin
               if (edge_q && in_win) begin
                  cnt_nxt = CNT_ONE;
                  if (pcnt == PRE_LAST) begin
                     state_nxt = DATA;
                     pcnt_nxt  = '0;
                     bcnt_nxt  = '0;
                  end else begin
                     pcnt_nxt = pcnt + 4'd1;
                  end
               end else if (edge_q) begin
                  cnt_nxt  = CNT_ONE;
                  pcnt_nxt = 4'd1;
               end else if (timeout) begin
                  state_nxt = HUNT;
                  pcnt_nxt  = '0;
               end
            end
            DATA: begin
               if (edge_q && !in_win) begin
                  err_nxt   = 1'b1;
                  state_nxt = HUNT;
                  sh_nxt    = '0;
                  bcnt_nxt  = '0;
               end else if (edge_q || timeout) begin
                  sh_nxt  = pkt_word;
                  cnt_nxt = edge_q ? CNT_ONE : CNT_RESYNC;
                  if (bcnt == 7'd63) begin
                     deliver   = 1'b1;
                     state_nxt = HUNT;
                     bcnt_nxt  = '0;
                     sh_nxt    = '0;
                  end else begin
                     bcnt_nxt = bcnt + 7'd1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         state    <= IDLE;
         cnt      <= '0;
         pcnt     <= '0;
         bcnt     <= '0;
         sh       <= '0;
         rx_err   <= 1'b0;
         pkt_rec  <= 1'b0;
         pkt_data <= '0;
         overflow <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         pcnt   <= pcnt_nxt;
         bcnt   <= bcnt_nxt;
         sh     <= sh_nxt;
         rx_err <= err_nxt;
         if (pkt_ack)
            overflow <= 1'b0;
         if (deliver && pkt_rec && !pkt_ack)
            overflow <= 1'b1;
         if (deliver)
            pkt_rec <= 1'b1;
         else if (pkt_ack)
            pkt_rec <= 1'b0;
         // An acknowledge in the delivery cycle frees the slot, so the new word is taken.
         if (deliver && (!pkt_rec || pkt_ack))
            pkt_data <= pkt_word;
      end
   end

endmodule

// File: tb/tb_rfin_pkt_receiver.sv
// Directed bench for rfin_pkt_receiver with BIT_CLKS=100, WIN_CLKS=10; table of frames plus
// hand-written overflow, delivery-latency, reset and RX-drop sequences.
module tb_rfin_pkt_receiver;

   localparam int BIT = 100;
   localparam int WIN = 10;
`ifdef RFRX_GLITCH_FILTER_EN
   localparam int LAT_X  = 1;
   localparam bit GLITCH = 1'b1;
`else
   localparam int LAT_X  = 0;
   localparam bit GLITCH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rfin, RX, pkt_ack;
   logic        pkt_rec, rx_busy, rx_err, overflow;
   logic [63:0] pkt_data;

   rfin_pkt_receiver #(.BIT_CLKS(BIT), .WIN_CLKS(WIN), .PRE_LEN(8)) dut (
      .i_PCLK(clk), .i_PRESET(rst), .rfin(rfin), .RX(RX), .pkt_ack(pkt_ack),
      .pkt_rec(pkt_rec), .pkt_data(pkt_data), .rx_busy(rx_busy), .rx_err(rx_err),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int   checks = 0, failures = 0;
   int   cyc = 0, err_cnt = 0, rise_cyc = -1, pre8_c0 = 0;
   logic rec_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_err) err_cnt <= err_cnt + 1;
      if (pkt_rec && !rec_prev) rise_cyc <= cyc;
      rec_prev <= pkt_rec;
   end

   typedef struct packed {
      logic [63:0] pl;
      bit          jit;
      int          early;
      int          skip;
      int          nslots;
      bit          exp_rec;
      logic [63:0] exp_data;
      int          exp_err;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int jit_of(input int i);
      case (i % 6)
         0, 3:    return 0;
         1, 2:    return 8;
         default: return -8;
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Slots 0..7 carry the preamble, slots 8..71 the payload MSB first; pulses are 2 cycles at mid-slot.
   task automatic send_frame(input logic [63:0] pl, input bit jit, input int early_slot,
                             input int skip_slot, input int nslots, input bit glitch);
      int t, pidx, start;
      bit has;
      t = 0;
      pidx = 0;
      for (int s = 0; s < nslots; s++) begin
         if (glitch && s > 0) begin
            repeat (s*BIT + 10 - t) @(negedge clk);
            rfin = 1'b1;
            @(negedge clk);
            rfin = 1'b0;
            t = s*BIT + 11;
         end
         has = (s < 8) ? 1'b1 : pl[71-s];
         if (s == skip_slot) has = 1'b0;
         if (has) begin
            start = s*BIT + BIT/2 + (jit ? jit_of(pidx) : 0) + ((s == early_slot) ? -15 : 0);
            repeat (start - t) @(negedge clk);
            if (s == 7) pre8_c0 = cyc + 1;
            rfin = 1'b1;
            repeat (2) @(negedge clk);
            rfin = 1'b0;
            t = start + 2;
            pidx++;
         end
      end
      repeat ((nslots-1)*BIT + BIT/2 + 40 - t) @(negedge clk);
   endtask

   task automatic ack();
      pkt_ack = 1'b1;
      @(negedge clk);
      pkt_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int e0;
      logic [63:0] x_pl, y_pl, p2;

      vt[0] = '{64'h8123456789ABCD0F, 1'b0, -1, -1, 72, 1'b1, 64'h8123456789ABCD0F, 0};
      vt[1] = '{64'hA5A50000FFFF1234, 1'b1, -1, -1, 72, 1'b1, 64'hA5A50000FFFF1234, 0};
      vt[2] = '{64'hA5A50000FFFF1234, 1'b0,  8, -1,  9, 1'b0, 64'hA5A50000FFFF1234, 1};
      vt[3] = '{64'h0,                1'b0, -1,  5,  8, 1'b0, 64'hA5A50000FFFF1234, 0};
      vt[4] = '{64'h0123456789ABCDEF, 1'b0, -1, -1, 72, 1'b1, 64'h0123456789ABCDEF, 0};

      rst = 1'b1; RX = 1'b0; rfin = 1'b0; pkt_ack = 1'b0;
      idle(3);
      chk("reset pkt_rec",  pkt_rec,  0);
      chk("reset pkt_data", pkt_data, 0);
      chk("reset rx_busy",  rx_busy,  0);
      chk("reset rx_err",   rx_err,   0);
      chk("reset overflow", overflow, 0);
      rst = 1'b0;
      RX  = 1'b1;
      idle(5);
      chk("hunt rx_busy", rx_busy, 0);

      for (int i = 0; i < 5; i++) begin
         e0 = err_cnt;
         send_frame(vt[i].pl, vt[i].jit, vt[i].early, vt[i].skip, vt[i].nslots, GLITCH);
         idle(200);
         chk($sformatf("v%0d pkt_rec", i),  pkt_rec,  vt[i].exp_rec);
         chk($sformatf("v%0d pkt_data", i), pkt_data, vt[i].exp_data);
         chk($sformatf("v%0d rx_err pulses", i), 64'(err_cnt - e0), 64'(vt[i].exp_err));
         chk($sformatf("v%0d rx_busy", i),  rx_busy,  0);
         chk($sformatf("v%0d overflow", i), overflow, 0);
         if (vt[i].exp_rec) begin
            ack();
            chk($sformatf("v%0d ack pkt_rec", i),  pkt_rec,  0);
            chk($sformatf("v%0d ack pkt_data", i), pkt_data, vt[i].exp_data);
         end
      end

      // back-to-back frames without acknowledge
      x_pl = 64'h1122334455667788;
      y_pl = 64'h99AABBCCDDEEFF00;
      send_frame(x_pl, 1'b0, -1, -1, 72, 1'b0);
      idle(50);
      chk("b2b first pkt_rec",  pkt_rec,  1);
      chk("b2b first overflow", overflow, 0);
      send_frame(y_pl, 1'b0, -1, -1, 72, 1'b0);
      idle(50);
      chk("b2b overflow", overflow, 1);
      chk("b2b pkt_rec",  pkt_rec,  1);
      chk("b2b pkt_data", pkt_data, x_pl);
      ack();
      chk("b2b ack pkt_rec",  pkt_rec,  0);
      chk("b2b ack overflow", overflow, 0);
      chk("b2b ack pkt_data", pkt_data, x_pl);

      // all-zero payload: delivery one cycle after the 64th window closes
      send_frame(64'h0, 1'b0, -1, -1, 72, GLITCH);
      idle(20);
      chk("zero rise cycle", 64'(rise_cyc), 64'(pre8_c0 + 6413 + LAT_X));
      chk("zero pkt_rec",    pkt_rec,  1);
      chk("zero pkt_data",   pkt_data, 0);

      // acknowledge in the same cycle as the next delivery
      p2 = 64'hFEDCBA9876543210;
      fork
         send_frame(p2, 1'b0, -1, -1, 72, 1'b0);
         begin
            repeat (751 + 6412 + LAT_X) @(negedge clk);
            pkt_ack = 1'b1;
            @(negedge clk);
            pkt_ack = 1'b0;
         end
      join
      idle(20);
      chk("ack+deliver pkt_rec",  pkt_rec,  1);
      chk("ack+deliver pkt_data", pkt_data, p2);
      chk("ack+deliver overflow", overflow, 0);

      // asynchronous reset mid-DATA
      fork
         send_frame(64'hFFFF0000FFFF0000, 1'b0, -1, -1, 30, 1'b0);
         begin
            repeat (2050) @(negedge clk);
            chk("mid-data rx_busy", rx_busy, 1);
            #3 rst = 1'b1;
            #1;
            chk("async rst pkt_rec",  pkt_rec,  0);
            chk("async rst pkt_data", pkt_data, 0);
            chk("async rst rx_busy",  rx_busy,  0);
            chk("async rst rx_err",   rx_err,   0);
            chk("async rst overflow", overflow, 0);
         end
      join
      idle(5);
      rst = 1'b0;
      idle(300);

      // RX dropped mid-frame
      fork
         send_frame(64'hFFFF0000FFFF0000, 1'b0, -1, -1, 30, 1'b0);
         begin
            repeat (2050) @(negedge clk);
            chk("pre-drop rx_busy", rx_busy, 1);
            RX = 1'b0;
            repeat (2) @(negedge clk);
            chk("rx drop rx_busy", rx_busy, 0);
         end
      join
      idle(50);
      chk("rx drop pkt_rec",  pkt_rec,  0);
      chk("rx drop overflow", overflow, 0);
      RX = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
